hazard_unit_mc: RTL

Parametrised successor to the five-stage pipeline hazard unit. Same job as before: forwarding select, load-use stall and taken-branch flush for the F/D/E/M/WB pipeline. Adds multi-cycle execute ops with configurable latency, an E-stage hold with M-stage bubble injection, and a saturating stall-cycle counter. It sits beside the controller and drives the enable and clear inputs of the F/D, D/E and E/M pipeline registers.

---
 rtl/hazard_unit_mc_if.sv | 43 ++++
 rtl/hazard_unit_mc.sv | 101 ++++++++++
 2 files changed

// File: rtl/hazard_unit_mc_if.sv
// rtl/hazard_unit_mc_if.sv - hazard unit signal bundle: pipeline-side master, hazard-unit slave
interface hazard_unit_mc_if #(
    parameter int ADDRESSWIDTH = 4,
    parameter int CNTWIDTH     = 32
);
    logic [ADDRESSWIDTH-1:0] reg1AddressD;
    logic [ADDRESSWIDTH-1:0] reg2AddressD;
    logic [ADDRESSWIDTH-1:0] reg1AddressE;
    logic [ADDRESSWIDTH-1:0] reg2AddressE;
    logic [ADDRESSWIDTH-1:0] regDestinationAddressE;
    logic [ADDRESSWIDTH-1:0] regDestinationAddressM;
    logic [ADDRESSWIDTH-1:0] regDestinationAddressWB;
    logic                    writeEnableDM;
    logic                    writeEnableDWB;
    logic                    resultSelectorWBE;
    logic                    multiE;
    logic                    takeBranchE;
    logic [1:0]              data1ForwardSelectorE;
    logic [1:0]              data2ForwardSelectorE;
    logic                    stallF;
    logic                    stallD;
    logic                    stallE;
    logic                    flushD;
    logic                    flushE;
    logic                    bubbleM;
    logic [CNTWIDTH-1:0]     stallCount;

    modport master (
        output reg1AddressD, reg2AddressD, reg1AddressE, reg2AddressE,
        output regDestinationAddressE, regDestinationAddressM, regDestinationAddressWB,
        output writeEnableDM, writeEnableDWB, resultSelectorWBE, multiE, takeBranchE,
        input  data1ForwardSelectorE, data2ForwardSelectorE,
        input  stallF, stallD, stallE, flushD, flushE, bubbleM, stallCount
    );

    modport slave (
        input  reg1AddressD, reg2AddressD, reg1AddressE, reg2AddressE,
        input  regDestinationAddressE, regDestinationAddressM, regDestinationAddressWB,
        input  writeEnableDM, writeEnableDWB, resultSelectorWBE, multiE, takeBranchE,
        output data1ForwardSelectorE, data2ForwardSelectorE,
        output stallF, stallD, stallE, flushD, flushE, bubbleM, stallCount
    );
endinterface

// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - F/D/E/M/WB hazard unit with multi-cycle E hold and stall counter
// Optional HAZARD_R0_HARDWIRED_EN: register 0 never matches for forwarding or load-use.
module hazard_unit_mc #(
    parameter int ADDRESSWIDTH = 4,
    parameter int EXLAT        = 4,
    parameter int CNTWIDTH     = 32
) (
    input  logic             clock,
    input  logic             reset,
    hazard_unit_mc_if.slave  hz
);
    localparam logic [3:0] HOLD_LAST = 4'(EXLAT - 1);

    logic [3:0]          cnt_q, cnt_d;
    logic [CNTWIDTH-1:0] stall_count_q, stall_count_d;

    logic       hold_e, load_use;
    logic [1:0] fwd1, fwd2;
    logic       stall_f, stall_d, stall_e, flush_d, flush_e, bubble_m;

    function automatic logic addr_match(input logic [ADDRESSWIDTH-1:0] a,
                                        input logic [ADDRESSWIDTH-1:0] b);
`ifdef HAZARD_R0_HARDWIRED_EN
        return (a == b) && (a != '0);
`else
        return a == b;
`endif
    endfunction

    function automatic logic [1:0] fwd_sel(input logic                    we_m,
                                           input logic [ADDRESSWIDTH-1:0] rd_m,
                                           input logic                    we_wb,
                                           input logic [ADDRESSWIDTH-1:0] rd_wb,
                                           input logic [ADDRESSWIDTH-1:0] src);
        if (we_m && addr_match(rd_m, src)) begin
            return 2'b10;
        end
        if (we_wb && addr_match(rd_wb, src)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    always_comb begin
        hold_e   = hz.multiE && (cnt_q < HOLD_LAST);
        load_use = hz.resultSelectorWBE &&
                   (addr_match(hz.regDestinationAddressE, hz.reg1AddressD) ||
                    addr_match(hz.regDestinationAddressE, hz.reg2AddressD));

        fwd1     = 2'b00;
        fwd2     = 2'b00;
        stall_f  = 1'b0;
        stall_d  = 1'b0;
        stall_e  = 1'b0;
        bubble_m = 1'b0;
        flush_d  = 1'b1;
        flush_e  = 1'b1;

        if (!reset) begin
            fwd1     = fwd_sel(hz.writeEnableDM, hz.regDestinationAddressM,
                               hz.writeEnableDWB, hz.regDestinationAddressWB, hz.reg1AddressE);
            fwd2     = fwd_sel(hz.writeEnableDM, hz.regDestinationAddressM,
                               hz.writeEnableDWB, hz.regDestinationAddressWB, hz.reg2AddressE);
            // A taken branch squashes the load-use stall; a multi-cycle hold overrides both.
            stall_f  = hold_e || (load_use && !hz.takeBranchE);
            stall_d  = stall_f;
            stall_e  = hold_e;
            bubble_m = hold_e;
            flush_d  = hz.takeBranchE;
            flush_e  = !hold_e && (hz.takeBranchE || load_use);
        end
    end

    always_comb begin
        cnt_d         = (!reset && hold_e) ? cnt_q + 4'd1 : 4'd0;
        stall_count_d = stall_count_q;
        if (stall_f && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q         <= 4'd0;
            stall_count_q <= '0;
        end else begin
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign hz.data1ForwardSelectorE = fwd1;
    assign hz.data2ForwardSelectorE = fwd2;
    assign hz.stallF                = stall_f;
    assign hz.stallD                = stall_d;
    assign hz.stallE                = stall_e;
    assign hz.flushD                = flush_d;
    assign hz.flushE                = flush_e;
    assign hz.bubbleM               = bubble_m;
    assign hz.stallCount            = stall_count_q;
endmodule
